// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIVU = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per cycle.
// res_hi_o/res_lo_o present the values the step in progress will write.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  // acc_q: MUL upper product / DIVU remainder; lo_q: MUL multiplier->lower product / DIVU dividend->quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q;
  logic             div_q;
  logic             dz_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opd_q};
    acc_d    = acc_q;
    lo_d     = lo_q;
    if (div_q) begin
      // Divisor zero never borrows: quotient fills with ones, remainder shifts in the dividend.
      if (!div_diff[WIDTH]) begin
        acc_d = div_diff[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_sh[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      lo_q  <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= '0;
      lo_q  <= div_i ? a_i : b_i;
      opd_q <= div_i ? b_i : a_i;
      div_q <= div_i;
      dz_q  <= div_i && (b_i == '0);
      cnt_q <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o    = cnt_q;
  assign last_o   = (cnt_q == CNT_W'(WIDTH - 1));
  assign dz_o     = dz_q;
  assign res_hi_o = acc_d;
  assign res_lo_o = lo_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative MUL/DIVU.
// Handshake: start is accepted on any edge where busy=0; done pulses for one cycle when results update.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             ZF,
  output logic             DZ,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zf_q, zf_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] sc_out;

  logic             md_load, md_step;
  logic [CNT_W-1:0] md_cnt;
  logic             md_last, md_dz;
  logic [WIDTH-1:0] md_hi, md_lo;

  alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (md_load),
    .step_i   (md_step),
    .div_i    (op == OP_DIVU),
    .a_i      (A),
    .b_i      (B),
    .cnt_o    (md_cnt),
    .last_o   (md_last),
    .dz_o     (md_dz),
    .res_hi_o (md_hi),
    .res_lo_o (md_lo)
  );

  always_comb begin
    sc_out = '0;
    case (op)
      OP_AND:  sc_out = A & B;
      OP_OR:   sc_out = A | B;
      OP_ADD:  sc_out = A + B;
      OP_SUB:  sc_out = A - B;
      OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_out = {{(WIDTH-1){1'b0}}, (A < B)};
      default: sc_out = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zf_d    = zf_q;
    dz_d    = dz_q;
    md_load = 1'b0;
    md_step = 1'b0;
    case (state_q)
      ST_RUN: begin
        md_step = 1'b1;
        if (md_last) begin
          state_d = ST_DONE;
          out_d   = md_lo;
          hi_d    = md_hi;
          dz_d    = md_dz;
          zf_d    = (md_lo == '0);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          if (is_iter(op)) begin
            state_d = ST_RUN;
            md_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            out_d   = sc_out;
            hi_d    = '0;
            dz_d    = 1'b0;
            zf_d    = (sc_out == '0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      zf_q    <= 1'b1;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zf_q    <= zf_d;
      dz_q    <= dz_d;
    end
  end

  assign out     = out_q;
  assign hi      = hi_q;
  assign ZF      = zf_q;
  assign DZ      = dz_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] out, hi;
  logic         zf, dz, busy, done;
  logic [1:0]   state;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic seen_done;
  logic busy_ok;

  alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .A       (a),
    .B       (b),
    .out     (out),
    .hi      (hi),
    .ZF      (zf),
    .DZ      (dz),
    .busy    (busy),
    .done    (done),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // pulse start for one accept edge, then wait (bounded) for done; lat = start->done cycles
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
    step(); step();
    chk("rst_out", 64'(out), 64'h0);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_zf", 64'(zf), 64'h1);
    chk("rst_dz", 64'(dz), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_state", 64'(state), 64'(ST_IDLE));
    rst_n = 1'b1;
    step();

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_out", 64'(out), 64'h0);
    chk("add_zf", 64'(zf), 64'h1);
    step();
    chk("done_one_cycle", 64'(done), 64'h0);

    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    chk("slt_out", 64'(out), 64'h1);
    chk("slt_zf", 64'(zf), 64'h0);
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_out", 64'(out), 64'h0);
    chk("sltu_zf", 64'(zf), 64'h1);
    run_op(OP_SUB, 32'd5, 32'd7);
    chk("sub_out", 64'(out), 64'hFFFF_FFFE);
    run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("and_out", 64'(out), 64'hF000_F000);
    step();

    // MUL with per-cycle busy check
    op = OP_MUL; a = 32'h0001_0000; b = 32'h0001_0000; start = 1'b1;
    step();
    start = 1'b0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      if (!busy || done) busy_ok = 1'b0;
      step();
    end
    chk("mul_busy_1_32", 64'(busy_ok), 64'h1);
    chk("mul_done_33", 64'(done), 64'h1);
    chk("mul_busy_33", 64'(busy), 64'h0);
    chk("mul_out", 64'(out), 64'h0);
    chk("mul_hi", 64'(hi), 64'h1);
    chk("mul_zf", 64'(zf), 64'h1);
    chk("mul_dz", 64'(dz), 64'h0);

    // operand/op/start changes during RUN must not disturb the result
    op = OP_MUL; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    step();
    op = OP_ADD; a = 32'h1234_5678; b = 32'h0; start = 1'b1;
    step();
    start = 1'b0; op = OP_DIVU; a = 32'h0; b = 32'h0;
    lat = 2;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk("mul2_lat", 64'(lat), 64'd33);
    chk("mul2_out", 64'(out), 64'h0000_0001);
    chk("mul2_hi", 64'(hi), 64'hFFFF_FFFE);
    step();
    chk("mul2_busy_start_ignored", 64'(busy), 64'h0);

    run_op(OP_DIVU, 32'd100, 32'd7);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_out", 64'(out), 64'd14);
    chk("div_hi", 64'(hi), 64'd2);
    chk("div_dz", 64'(dz), 64'h0);
    run_op(OP_DIVU, 32'd5, 32'd0);
    chk("dz_lat", 64'(lat), 64'd33);
    chk("dz_out", 64'(out), 64'hFFFF_FFFF);
    chk("dz_hi", 64'(hi), 64'd5);
    chk("dz_flag", 64'(dz), 64'h1);
    chk("dz_zf", 64'(zf), 64'h0);

    run_op(4'd9, 32'h55, 32'hAA);
    chk("bad_op_lat", 64'(lat), 64'd1);
    chk("bad_op_out", 64'(out), 64'h0);
    chk("bad_op_hi", 64'(hi), 64'h0);
    chk("bad_op_dz", 64'(dz), 64'h0);
    chk("bad_op_zf", 64'(zf), 64'h1);
    step();

    // back-to-back: second start issued in the done cycle
    op = OP_ADD; a = 32'd2; b = 32'd3; start = 1'b1;
    step();
    chk("b2b_done1", 64'(done), 64'h1);
    chk("b2b_out1", 64'(out), 64'd5);
    op = OP_OR; a = 32'hF0; b = 32'h0F;
    step();
    start = 1'b0;
    chk("b2b_done2", 64'(done), 64'h1);
    chk("b2b_out2", 64'(out), 64'hFF);
    a = 32'h0; b = 32'h0;
    step(); step();
    chk("hold_out", 64'(out), 64'hFF);
    chk("hold_done", 64'(done), 64'h0);

    // reset aborts a MUL in flight; earlier ADD start is ignored
    op = OP_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
    step();
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 10) begin
        op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
      end
      if (c == 20) begin
        rst_n = 1'b0; op = OP_ADD; start = 1'b1;
      end
      if (done) seen_done = 1'b1;
      step();
      if (c == 10) start = 1'b0;
    end
    chk("abort_no_done", 64'(seen_done), 64'h0);
    chk("abort_out", 64'(out), 64'h0);
    chk("abort_hi", 64'(hi), 64'h0);
    chk("abort_zf", 64'(zf), 64'h1);
    chk("abort_dz", 64'(dz), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    chk("abort_state", 64'(state), 64'(ST_IDLE));
    rst_n = 1'b1; start = 1'b0;
    step(); step();
    chk("post_rst_no_done", 64'(done), 64'h0);
    run_op(OP_ADD, 32'd40, 32'd2);
    chk("recover_out", 64'(out), 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
